// File: rtl/proc_ctrl_pkg.sv
// Shared types and instruction field positions for the processor control unit.
`timescale 1ns/1ps
package proc_ctrl_pkg;

    localparam int PC_W      = 8;
    localparam int D_ADDR_W  = 8;
    localparam int RF_ADDR_W = 4;
    localparam int INSTR_W   = 16;

    localparam int OPC_LSB    = 12;
    localparam int OPC_W      = 4;
    localparam int RA_LSB     = 8;
    localparam int RB_LSB     = 4;
    localparam int RD_LSB     = 0;
    localparam int LD_ADR_LSB = 4;
    localparam int ST_ADR_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_LOAD_A,
        S_LOAD_B,
        S_STORE_A,
        S_STORE_B,
        S_ALU_A,
        S_ALU_B,
        S_HALT
    } state_e;

endpackage

// File: rtl/processor_control_unit_program_counter.sv
// Program counter: async clear, advances by one when inc_en is high, wraps at 2^W.
`timescale 1ns/1ps
module program_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_en,
    output logic [W-1:0] pc
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_en) begin
            pc_d = pc_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/processor_control_unit.sv
// Multi-cycle sequencer for the RF/ALU/data memory; NOOP takes 3 cycles, LOAD/STORE/ADD/SUB 5.
// Outputs decode from state and ir only; no handshake, the datapath always keeps up.
`timescale 1ns/1ps
module processor_control_unit
    import proc_ctrl_pkg::*;
#(
    parameter int PC_W      = proc_ctrl_pkg::PC_W,
    parameter int D_ADDR_W  = proc_ctrl_pkg::D_ADDR_W,
    parameter int RF_ADDR_W = proc_ctrl_pkg::RF_ADDR_W,
    parameter int INSTR_W   = proc_ctrl_pkg::INSTR_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [PC_W-1:0]      i_addr,
    input  logic [INSTR_W-1:0]   i_rdata,
    output logic [D_ADDR_W-1:0]  d_addr,
    output logic                 d_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic                 rf_we,
    output logic                 rf_wsel,
    output logic [RF_ADDR_W-1:0] rf_ra_addr,
    output logic [RF_ADDR_W-1:0] rf_rb_addr,
    output logic                 alu_op,
    output logic                 halted
);

    state_e             state_q;
    state_e             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic [PC_W-1:0]    pc;
    logic [OPC_W-1:0]   opc;

    // The pc only ever moves while the fetched word is being latched.
    program_counter #(.W(PC_W)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_en  (state_q == S_LATCH),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign opc    = ir_q[OPC_LSB +: OPC_W];
    assign i_addr = pc;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        d_addr     = '0;
        d_we       = 1'b0;
        rf_waddr   = '0;
        rf_we      = 1'b0;
        rf_wsel    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_op     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_INIT:  state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = i_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opc)
                    OP_LOAD:        state_d = S_LOAD_A;
                    OP_STORE:       state_d = S_STORE_A;
                    OP_ADD, OP_SUB: state_d = S_ALU_A;
                    OP_HALT:        state_d = S_HALT;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_LOAD_A: begin
                d_addr  = ir_q[LD_ADR_LSB +: D_ADDR_W];
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                d_addr   = ir_q[LD_ADR_LSB +: D_ADDR_W];
                rf_wsel  = 1'b1;
                rf_waddr = ir_q[RD_LSB +: RF_ADDR_W];
                rf_we    = 1'b1;
                state_d  = S_FETCH;
            end
            S_STORE_A: begin
                rf_ra_addr = ir_q[RA_LSB +: RF_ADDR_W];
                state_d    = S_STORE_B;
            end
            S_STORE_B: begin
                rf_ra_addr = ir_q[RA_LSB +: RF_ADDR_W];
                d_addr     = ir_q[ST_ADR_LSB +: D_ADDR_W];
                d_we       = 1'b1;
                state_d    = S_FETCH;
            end
            S_ALU_A: begin
                rf_ra_addr = ir_q[RA_LSB +: RF_ADDR_W];
                rf_rb_addr = ir_q[RB_LSB +: RF_ADDR_W];
                state_d    = S_ALU_B;
            end
            // Operands were read in ALU_A, so Rd may alias Ra/Rb here.
            S_ALU_B: begin
                rf_ra_addr = ir_q[RA_LSB +: RF_ADDR_W];
                rf_rb_addr = ir_q[RB_LSB +: RF_ADDR_W];
                alu_op     = (opc == OP_SUB);
                rf_wsel    = 1'b0;
                rf_waddr   = ir_q[RD_LSB +: RF_ADDR_W];
                rf_we      = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_processor_control_unit.sv
// Directed bench for processor_control_unit with a behavioural sync-read ROM.
`timescale 1ns/1ps
module tb_processor_control_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  i_addr;
    logic [15:0] i_rdata = '0;
    logic [7:0]  d_addr;
    logic        d_we;
    logic [3:0]  rf_waddr;
    logic        rf_we;
    logic        rf_wsel;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic        alu_op;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] rom [256];

    always #5 clk = ~clk;

    always @(posedge clk) i_rdata <= rom[i_addr];

    processor_control_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_op     (alu_op),
        .halted     (halted)
    );

    logic [32:0] obs;
    assign obs = {i_addr, d_addr, d_we, rf_waddr, rf_we, rf_wsel,
                  rf_ra_addr, rf_rb_addr, alu_op, halted};

    function automatic logic [32:0] ev(input logic [7:0] ia, input logic [7:0] da,
                                       input logic dwe, input logic [3:0] wa,
                                       input logic we, input logic wsel,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic op, input logic h);
        return {ia, da, dwe, wa, we, wsel, ra, rb, op, h};
    endfunction

    function automatic logic [32:0] idle(input logic [7:0] ia);
        return ev(ia, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [32:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [32:0] exp);
        step();
        chk(tag, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset", idle(8'h00));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h21A3;
        rom[1] = 16'h3125;
        rom[2] = 16'h4125;
        rom[3] = 16'h14C0;
        rom[4] = 16'h0000;
        rom[5] = 16'h6123;
        rom[6] = 16'hF0FF;
        rom[7] = 16'h5000;

        do_reset();
        chk("init", idle(8'h00));

        cyc("ld_fetch",  idle(8'h00));
        cyc("ld_latch",  idle(8'h00));
        cyc("ld_decode", idle(8'h01));
        cyc("ld_a", ev(8'h01, 8'h1A, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
        cyc("ld_b", ev(8'h01, 8'h1A, 1'b0, 4'h3, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0));

        cyc("add_fetch",  idle(8'h01));
        cyc("add_latch",  idle(8'h01));
        cyc("add_decode", idle(8'h02));
        cyc("add_a", ev(8'h02, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0));
        cyc("add_b", ev(8'h02, 8'h00, 1'b0, 4'h5, 1'b1, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0));

        cyc("sub_fetch",  idle(8'h02));
        cyc("sub_latch",  idle(8'h02));
        cyc("sub_decode", idle(8'h03));
        cyc("sub_a", ev(8'h03, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0));
        cyc("sub_b", ev(8'h03, 8'h00, 1'b0, 4'h5, 1'b1, 1'b0, 4'h1, 4'h2, 1'b1, 1'b0));

        cyc("st_fetch",  idle(8'h03));
        cyc("st_latch",  idle(8'h03));
        cyc("st_decode", idle(8'h04));
        cyc("st_a", ev(8'h04, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0));
        cyc("st_b", ev(8'h04, 8'hC0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0));

        cyc("nop0_fetch",  idle(8'h04));
        cyc("nop0_latch",  idle(8'h04));
        cyc("nop0_decode", idle(8'h05));
        cyc("nop6_fetch",  idle(8'h05));
        cyc("nop6_latch",  idle(8'h05));
        cyc("nop6_decode", idle(8'h06));
        cyc("nopf_fetch",  idle(8'h06));
        cyc("nopf_latch",  idle(8'h06));
        cyc("nopf_decode", idle(8'h07));

        cyc("halt_fetch",  idle(8'h07));
        cyc("halt_latch",  idle(8'h07));
        cyc("halt_decode", idle(8'h08));
        for (int i = 0; i < 100; i++) begin
            cyc("halt_hold", ev(8'h08, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1));
        end

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        do_reset();
        chk("init2", idle(8'h00));
        for (int i = 0; i < 255; i++) begin
            step();
            step();
            cyc("noop_decode", idle(8'(i + 1)));
        end
        cyc("wrap_fetch_255", idle(8'hFF));
        cyc("wrap_latch_255", idle(8'hFF));
        cyc("wrap_decode",    idle(8'h00));
        cyc("wrap_fetch_0",   idle(8'h00));

        rom[0] = 16'h3125;
        do_reset();
        chk("init3", idle(8'h00));
        step();
        step();
        step();
        cyc("rst_alu_a", ev(8'h01, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0));
        cyc("rst_alu_b", ev(8'h01, 8'h00, 1'b0, 4'h5, 1'b1, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_drop", idle(8'h00));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_init",   idle(8'h00));
        cyc("rst_fetch",  idle(8'h00));
        cyc("rst_latch",  idle(8'h00));
        cyc("rst_decode", idle(8'h01));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
